dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (addr, datain, dataout, 3-bit memop, we) between two requesters.
- m0 is the rv32 core load/store path; m1 is a secondary master (program loader or debug DMA).
- Sequences each access as grant → memory busy for MEM_LAT cycles → one-cycle done with read data.
- Round-robin arbitration, with an optional lock that lets m1 run back-to-back transfers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory cycles per access (legal range 1..15); read data is valid at the end of the last busy cycle.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request; held until m0_gnt.
- m0_we  in  1  m0 write enable.
- m0_op  in  3  m0 memop (same encoding as core dmemop).
- m0_addr  in  AW  m0 address.
- m0_wdata  in  DW  m0 write data.
- m0_gnt  out  1  m0 command accepted this cycle (combinational).
- m0_done  out  1  m0 access complete (one-cycle pulse).
- m0_rdata  out  DW  m0 read data; valid with m0_done, held until the next m0_done.
- m1_req, m1_we, m1_op, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as m0, for m1.
- m1_lock  in  1  m1 keeps priority across consecutive accesses.
- mem_addr  out  AW  registered address to memory.
- mem_wdata  out  DW  registered write data.
- mem_op  out  3  registered memop.
- mem_we  out  1  write strobe.
- mem_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.
- owner  out  1  requester of the current or last access (0 = m0, 1 = m1).

Behaviour:
- Reset (reset=0, takes effect immediately):
  - state = IDLE, cnt = 0, last = 1 (so m0 wins the first tie), owner = 0.
  - All gnt/done/mem_we/busy = 0; mem_addr/mem_wdata/mem_op/rdata registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - gnt is asserted combinationally to the picked requester only.
  - Selection rule:
    - single requester → it wins;
    - both requesting → the one with index != last, except when last=1 and m1_lock=1, in which case m1 wins.
  - On a clock edge with a grant: latch we/op/addr/wdata of the winner into the mem_* registers, set owner and last to the winner, cnt = MEM_LAT, state → BUSY.
- BUSY:
  - mem_addr/mem_op/mem_wdata stay stable for the whole state.
  - mem_we = latched we only in the first BUSY cycle (cnt == MEM_LAT); exactly one write strobe per access.
  - cnt decrements each cycle.
  - When cnt == 1: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), state → DONE.
- DONE:
  - Owner's done = 1 for exactly one cycle; state → IDLE.
  - No grants are issued in DONE.
- Latency: req seen in IDLE at cycle 0 → gnt in cycle 0 → mem_* valid cycles 1..MEM_LAT → done in cycle MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles.
- Requester rules:
  - Inputs are sampled only in the cycle gnt=1; after that they may change.
  - Dropping req before gnt withdraws the request with no side effects.
- busy is asserted in BUSY and DONE.
- m1_lock is ignored when m1 was not the last grantee. m1_lock with no m1_req does not block m0.
- A simultaneous req from the owner during DONE is not granted until the following IDLE cycle; the tie rule applies then.
- Reset asserted mid-BUSY:
  - in-flight access is dropped;
  - mem_we deasserts asynchronously;
  - no done pulse is produced;
  - rdata clears to 0.
- mem_op value 3'b000 with we=0 is a legal read, with no special case.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - memop constants matching the core's 3-bit memop encoding;
  - CNT_W = 4.
- One sub-module, rr_pick: combinational 2-way picker.
  - Inputs: req[1:0], last, lock.
  - Outputs: one-hot gnt[1:0].
- The main module holds the FSM, counter and registers.

Test Plan:
- Single read, MEM_LAT=1: m0_req=1, m0_op=3'b010, m0_addr=32'h40, mem_rdata=32'hDEADBEEF
  → m0_gnt in cycle 0; mem_addr=32'h40 in cycle 1; m0_done in cycle 2 with m0_rdata=32'hDEADBEEF; busy high cycles 1–2.
- Write, MEM_LAT=3: m1 writes 32'h1234 to 32'h80
  → mem_we high in exactly one cycle (cycle 1); mem_addr stable cycles 1–3; m1_done in cycle 4; m1_rdata unchanged.
- Contention: m0_req and m1_req held high continuously from reset, lock=0
  → grant order m0, m1, m0, m1; each done routed only to its owner.
- Lock: m1 granted first, then both requesting with m1_lock=1 for 3 accesses
  → m1, m1, m1; after lock drops, m0 granted next.
- Async reset mid-BUSY (MEM_LAT=4, reset low in cycle 2)
  → mem_we, busy and all done signals drop without waiting for a clock edge; state IDLE; after release, m0 wins the first tie.
- Withdrawn request: m1_req high only during a cycle in which m0 holds the arbiter
  → m1 is never granted, and no mem activity occurs for m1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Core memop encoding (low two bits give the size, bit 2 marks unsigned loads).
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Width of the busy-cycle down-counter (covers latencies 1..15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker with an m1 priority lock.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the side that did not go last wins,
  // unless m1 went last and is holding the lock.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last && !lock) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core load/store path (m0) and a
// secondary master (m1). Each access is grant -> MEM_LAT busy cycles -> done.
//
// Handshake: mN_req acts as valid and mN_gnt as the accept. A requester keeps
// req and its command fields stable until it sees gnt; the fields are sampled
// only in the gnt cycle. Dropping req before gnt withdraws the request cleanly.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_op,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_op,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner,
  output state_t        dbg_state
);

  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             we_q;
  logic [1:0]       pick;
  logic             take;

  rr_pick u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .lock (m1_lock),
    .gnt  (pick)
  );

  // A command is accepted only while idle and someone was picked.
  assign take = (state_q == ST_IDLE) && (pick != 2'b00);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state strobes; strobes decode registered state so reset
  // removes them without waiting for an edge.
  always_comb begin
    state_d = state_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    m0_done = 1'b0;
    m1_done = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        m0_gnt = pick[0];
        m1_gnt = pick[1];
        if (pick != 2'b00) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        mem_we = we_q && (cnt_q == LAT_C);
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        m0_done = ~owner;
        m1_done = owner;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // Command latch, latency counter, arbitration history and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_op    <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (take) begin
        owner     <= pick[1];
        last_q    <= pick[1];
        we_q      <= pick[1] ? m1_we    : m0_we;
        mem_addr  <= pick[1] ? m1_addr  : m0_addr;
        mem_wdata <= pick[1] ? m1_wdata : m0_wdata;
        mem_op    <= pick[1] ? m1_op    : m0_op;
        cnt_q     <= LAT_C;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE && !we_q) begin
          if (owner) m1_rdata <= mem_rdata;
          else       m0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
